// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bus of the SRAM arbiter.
//   Fetch port : if_req (level), if_addr -> if_data, if_ready (1-cycle pulse)
//   Data port  : mem_read/mem_write (level), mem_addr, mem_wdata -> mem_rdata,
//                mem_ready (1-cycle pulse)
//   stall      : pipeline freeze while any access is outstanding
// master = CPU pipeline side, slave = arbiter side.
interface ram_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    input  if_data, if_ready, mem_rdata, mem_ready, stall
  );

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    output if_data, if_ready, mem_rdata, mem_ready, stall
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one asynchronous SRAM between instruction fetch and the
// MEM-stage data port. Round-robin grant in IDLE, then a multi-cycle sequence
// drives the active-low OE/WE/EN pins and the tri-state data bus.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   bus (slave)           requester handshake, ready pulses, stall
//   ram_oe/ram_we/ram_en  active-low SRAM controls (registered)
//   ram_addr[17:0]        SRAM address {ADDR_HI, word address}
//   ram_data[15:0]        bidirectional SRAM data bus
// Parameter ADDR_HI: upper two SRAM address bits, shared by both requesters.
module ram_arbiter #(
  parameter logic [1:0] ADDR_HI = 2'b00
) (
  input  logic                CLK,
  input  logic                RST,
  ram_arbiter_if.slave        bus,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                ram_en,
  output logic [17:0]         ram_addr,
  inout  wire  [15:0]         ram_data
);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_e;

  state_e      state;
  req_e        last_grant;
  req_e        owner;
  logic [15:0] wdata_q;
  logic        drive;
  logic        data_pending;
  logic        grant_data;

  // Data wins when it is the only requester, or when both are pending and
  // fetch was granted last.
  always_comb begin
    data_pending = bus.mem_read | bus.mem_write;
    grant_data   = data_pending && (!bus.if_req || (last_grant == REQ_FETCH));
  end

  // NOTE: the bus enable is a flop, not a decode of state, so the pin never
  // sees a combinational glitch when the state register changes.
  assign ram_data = drive ? wdata_q : 16'hzzzz;

  assign bus.stall = (bus.if_req & ~bus.if_ready) |
                     (data_pending & ~bus.mem_ready);

  // NOTE: all state and pin registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      last_grant    <= REQ_FETCH;
      owner         <= REQ_FETCH;
      wdata_q       <= '0;
      drive         <= 1'b0;
      ram_oe        <= 1'b1;
      ram_we        <= 1'b1;
      ram_en        <= 1'b1;
      ram_addr      <= '0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.if_data   <= '0;
      bus.mem_rdata <= '0;
    end else begin
      // Ready is a one-cycle pulse: cleared every cycle unless entering DONE.
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.if_req || data_pending) begin
            last_grant <= grant_data ? REQ_DATA : REQ_FETCH;
            owner      <= grant_data ? REQ_DATA : REQ_FETCH;
            ram_en     <= 1'b0;
            ram_addr   <= grant_data ? {ADDR_HI, bus.mem_addr}
                                     : {ADDR_HI, bus.if_addr};
            // Write takes priority over read on the data port.
            if (grant_data && bus.mem_write) begin
              wdata_q <= bus.mem_wdata;
              drive   <= 1'b1;
              state   <= WR_SETUP;
            end else begin
              ram_oe <= 1'b0;
              state  <= RD;
            end
          end
        end

        RD: begin
          if (owner == REQ_DATA) begin
            bus.mem_rdata <= ram_data;
            bus.mem_ready <= 1'b1;
          end else begin
            bus.if_data   <= ram_data;
            bus.if_ready  <= 1'b1;
          end
          ram_oe <= 1'b1;
          ram_en <= 1'b1;
          state  <= DONE;
        end

        WR_SETUP: begin
          ram_we <= 1'b0;
          state  <= WR_PULSE;
        end

        WR_PULSE: begin
          ram_we <= 1'b1;
          state  <= WR_HOLD;
        end

        WR_HOLD: begin
          drive         <= 1'b0;
          ram_en        <= 1'b1;
          bus.mem_ready <= 1'b1;
          state         <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, table-driven bench for ram_arbiter with a
// behavioural asynchronous SRAM. A second instance checks ADDR_HI.
module tb_ram_arbiter;

  typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE, OP_RW} op_e;

  typedef struct {
    op_e         op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_oe;
    int          exp_we;
    int          exp_drv;
  } vec_t;

  logic CLK;
  logic RST;

  int checks;
  int failures;

  ram_arbiter_if bus ();
  logic        ram_oe, ram_we, ram_en;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;

  ram_arbiter #(.ADDR_HI(2'b00)) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .ram_oe   (ram_oe),
    .ram_we   (ram_we),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  ram_arbiter_if bus_hi ();
  logic        ram_oe_hi, ram_we_hi, ram_en_hi;
  logic [17:0] ram_addr_hi;
  wire  [15:0] ram_data_hi;

  ram_arbiter #(.ADDR_HI(2'b11)) u_dut_hi (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_hi),
    .ram_oe   (ram_oe_hi),
    .ram_we   (ram_we_hi),
    .ram_en   (ram_en_hi),
    .ram_addr (ram_addr_hi),
    .ram_data (ram_data_hi)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: combinational read while EN and OE are low, write latched on
  // the rising edge of WE.
  logic [15:0] sram [logic [17:0]];
  logic [15:0] sram_q;

  always @(ram_addr, ram_oe, ram_en) begin
    sram_q = sram.exists(ram_addr) ? sram[ram_addr] : 16'h0000;
  end

  always @(posedge ram_we) begin
    if (!RST && !ram_en) sram[ram_addr] = ram_data;
  end

  assign ram_data    = (!ram_en && !ram_oe) ? sram_q : 16'hzzzz;
  assign ram_data_hi = (!ram_en_hi && !ram_oe_hi) ? 16'h5A5A : 16'hzzzz;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drop_requests();
    bus.if_req    = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    int          oe_cnt;
    int          we_cnt;
    int          drv_cnt;
    bit          done;
    bit          addr_ok;
    bit          stall_ok;
    logic        rdy;
    logic [15:0] got;
    n = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0;
    done = 1'b0; addr_ok = 1'b1; stall_ok = 1'b1; got = '0;

    @(negedge CLK);
    case (v.op)
      OP_FETCH: begin bus.if_req = 1'b1; bus.if_addr = v.addr; end
      OP_READ:  begin bus.mem_read = 1'b1; bus.mem_addr = v.addr; end
      OP_WRITE: begin bus.mem_write = 1'b1; bus.mem_addr = v.addr;
                      bus.mem_wdata = v.wdata; end
      default:  begin bus.mem_read = 1'b1; bus.mem_write = 1'b1;
                      bus.mem_addr = v.addr; bus.mem_wdata = v.wdata; end
    endcase

    while (!done && n < 20) begin
      @(negedge CLK);
      n++;
      if (!ram_oe) oe_cnt++;
      if (!ram_we) we_cnt++;
      if (!ram_en && ram_oe && ram_data == v.wdata) drv_cnt++;
      if (!ram_en && ram_addr != {2'b00, v.addr}) addr_ok = 1'b0;
      rdy = (v.op == OP_FETCH) ? bus.if_ready : bus.mem_ready;
      if (rdy) begin
        done = 1'b1;
        got  = (v.op == OP_FETCH) ? bus.if_data : bus.mem_rdata;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        drop_requests();
      end else if (bus.stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    drop_requests();

    check($sformatf("v%0d_latency", idx), n, v.exp_lat);
    check($sformatf("v%0d_oe_cycles", idx), oe_cnt, v.exp_oe);
    check($sformatf("v%0d_we_cycles", idx), we_cnt, v.exp_we);
    check($sformatf("v%0d_drive_cycles", idx), drv_cnt, v.exp_drv);
    check($sformatf("v%0d_addr", idx), {31'd0, addr_ok}, 32'd1);
    check($sformatf("v%0d_stall", idx), {31'd0, stall_ok}, 32'd1);
    if (v.op == OP_FETCH || v.op == OP_READ)
      check($sformatf("v%0d_rdata", idx), {16'd0, got}, {16'd0, v.exp_data});

    @(negedge CLK);
    check($sformatf("v%0d_ready_pulse", idx),
          {30'd0, bus.if_ready, bus.mem_ready}, 32'd0);
    check($sformatf("v%0d_idle_pins", idx), {29'd0, ram_oe, ram_we, ram_en}, 32'd7);
  endtask

  vec_t vecs [8];

  initial begin
    int          n;
    int          served;
    int          order [3];
    bit          stall_ok;
    bit          both;
    logic [17:0] hi_addr;
    bit          hi_done;

    checks   = 0;
    failures = 0;

    RST = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus_hi.if_req = 1'b0; bus_hi.if_addr = '0; bus_hi.mem_read = 1'b0;
    bus_hi.mem_write = 1'b0; bus_hi.mem_addr = '0; bus_hi.mem_wdata = '0;
    sram[18'h00004] = 16'h0800;

    //            op        addr      wdata     exp_data  lat oe we drv
    vecs[0] = '{OP_FETCH, 16'h0004, 16'h0000, 16'h0800, 2, 1, 0, 0};
    vecs[1] = '{OP_WRITE, 16'h8000, 16'hBEEF, 16'h0000, 4, 0, 1, 3};
    vecs[2] = '{OP_READ,  16'h8000, 16'h0000, 16'hBEEF, 2, 1, 0, 0};
    vecs[3] = '{OP_RW,    16'h0010, 16'h1111, 16'h0000, 4, 0, 1, 3};
    vecs[4] = '{OP_READ,  16'h0010, 16'h0000, 16'h1111, 2, 1, 0, 0};
    vecs[5] = '{OP_FETCH, 16'h8000, 16'h0000, 16'hBEEF, 2, 1, 0, 0};
    vecs[6] = '{OP_WRITE, 16'h0004, 16'hA5A5, 16'h0000, 4, 0, 1, 3};
    vecs[7] = '{OP_FETCH, 16'h0004, 16'h0000, 16'hA5A5, 2, 1, 0, 0};

    // Reset state.
    #12;
    check("reset_pins", {29'd0, ram_oe, ram_we, ram_en}, 32'd7);
    check("reset_addr", {14'd0, ram_addr}, 32'd0);
    check("reset_ready", {30'd0, bus.if_ready, bus.mem_ready}, 32'd0);
    check("reset_data", {bus.if_data, bus.mem_rdata}, 32'd0);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of the WE pulse.
    @(negedge CLK);
    bus.mem_write = 1'b1; bus.mem_addr = 16'h0100; bus.mem_wdata = 16'h7777;
    n = 0;
    while (ram_we !== 1'b0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("rst_mid_we_reached", {31'd0, ram_we}, 32'd0);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_pins", {29'd0, ram_oe, ram_we, ram_en}, 32'd7);
    check("rst_mid_addr", {14'd0, ram_addr}, 32'd0);
    check("rst_mid_ready", {30'd0, bus.if_ready, bus.mem_ready}, 32'd0);
    check("rst_mid_data", {bus.if_data, bus.mem_rdata}, 32'd0);
    drop_requests();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_idle", {31'd0, ram_en}, 32'd1);
    // A fresh fetch must start from IDLE with normal latency.
    run_vec(8, vecs[7]);

    // Both requesters held from reset: data, fetch, data.
    RST = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    bus.mem_read = 1'b1; bus.mem_addr = 16'h8000;
    @(negedge CLK);
    RST = 1'b0;
    served = 0; n = 0; stall_ok = 1'b1; both = 1'b0;
    order[0] = -1; order[1] = -1; order[2] = -1;
    while (served < 3 && n < 40) begin
      @(negedge CLK);
      n++;
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      if (bus.mem_ready && bus.if_ready) both = 1'b1;
      if (bus.mem_ready) begin
        order[served] = 1;
        check($sformatf("rr_mem_rdata%0d", served), {16'd0, bus.mem_rdata}, 32'h0000BEEF);
        served++;
      end else if (bus.if_ready) begin
        order[served] = 0;
        check($sformatf("rr_if_data%0d", served), {16'd0, bus.if_data}, 32'h0000A5A5);
        served++;
      end
    end
    drop_requests();
    check("rr_served", served, 3);
    check("rr_order0", order[0], 1);
    check("rr_order1", order[1], 0);
    check("rr_order2", order[2], 1);
    check("rr_cycles", n, 8);
    check("rr_stall_held", {31'd0, stall_ok}, 32'd1);
    check("rr_no_double_ready", {31'd0, both}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("rr_stall_released", {31'd0, bus.stall}, 32'd0);

    // ADDR_HI = 2'b11 instance.
    @(negedge CLK);
    bus_hi.mem_read = 1'b1; bus_hi.mem_addr = 16'h1234;
    hi_addr = '0; hi_done = 1'b0; n = 0;
    while (!hi_done && n < 10) begin
      @(negedge CLK);
      n++;
      if (!ram_en_hi) hi_addr = ram_addr_hi;
      if (bus_hi.mem_ready) begin
        hi_done = 1'b1;
        bus_hi.mem_read = 1'b0;
      end
    end
    bus_hi.mem_read = 1'b0;
    check("hi_ram_addr", {14'd0, hi_addr}, 32'h00031234);
    check("hi_latency", n, 2);
    check("hi_rdata", {16'd0, bus_hi.mem_rdata}, 32'h00005A5A);
    check("hi_fetch_idle", {14'd0, bus_hi.if_ready, bus_hi.stall, ram_we_hi,
                            ram_oe_hi, bus_hi.if_data[11:0]}, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
